hack_cpu_seq: RTL and testbench

Multi-cycle Hack CPU sequencer: fetches 16-bit Hack instructions over a request/acknowledge instruction port, decodes A- and C-instructions, owns the A, D, PC and instruction registers, and drives the Hack ALU's X/Y operands and six control bits. It consumes the ALU result and ZR/NG flags for destination writeback and jump evaluation. Data memory is accessed over a separate request/acknowledge port, so both memories may have variable latency.

---
 rtl/hack_pkg.sv | 30 +++
 rtl/hack_cpu_seq_if.sv | 49 ++++
 rtl/hack_jump_cond.sv | 11 +
 rtl/hack_cpu_seq.sv | 114 +++++++++++
 tb/tb_hack_cpu_seq.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/hack_pkg.sv
// Shared Hack ISA definitions for the multi-cycle sequencer: widths, instruction
// field positions, FSM state encoding and the 15-bit PC increment.
package hack_pkg;

  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 15;

  localparam int IBIT_C  = 15;
  localparam int ABIT    = 12;
  localparam int CTRL_HI = 11;
  localparam int CTRL_LO = 6;
  localparam int DEST_HI = 5;
  localparam int DEST_LO = 3;
  localparam int JUMP_HI = 2;
  localparam int JUMP_LO = 0;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    MEM_RD,
    EXEC,
    MEM_WR
  } state_t;

  // Natural 15-bit wrap: 0x7FFF + 1 -> 0x0000.
  function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
    return pc + {{(ADDR_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/hack_cpu_seq_if.sv
// Bundle of the sequencer's instruction port, data port, ALU operand/result
// path and debug state taps. master = CPU sequencer, slave = memories/ALU/bench.
interface hack_cpu_seq_if;
  import hack_pkg::*;

  logic [ADDR_W-1:0] IMEM_ADDR;
  logic              IMEM_REQ;
  logic              IMEM_ACK;
  logic [DATA_W-1:0] IMEM_DATA;

  logic [ADDR_W-1:0] DMEM_ADDR;
  logic              DMEM_RD;
  logic              DMEM_WR;
  logic [DATA_W-1:0] DMEM_WDATA;
  logic [DATA_W-1:0] DMEM_RDATA;
  logic              DMEM_ACK;

  logic [DATA_W-1:0] ALU_X;
  logic [DATA_W-1:0] ALU_Y;
  logic [5:0]        ALU_CTRL;
  logic [DATA_W-1:0] ALU_OUT;
  logic              ALU_ZR;
  logic              ALU_NG;

  logic [ADDR_W-1:0] PC_OUT;
  logic [DATA_W-1:0] A_OUT;
  logic [DATA_W-1:0] D_OUT;

  modport master (
    output IMEM_ADDR, IMEM_REQ,
    input  IMEM_ACK, IMEM_DATA,
    output DMEM_ADDR, DMEM_RD, DMEM_WR, DMEM_WDATA,
    input  DMEM_RDATA, DMEM_ACK,
    output ALU_X, ALU_Y, ALU_CTRL,
    input  ALU_OUT, ALU_ZR, ALU_NG,
    output PC_OUT, A_OUT, D_OUT
  );

  modport slave (
    input  IMEM_ADDR, IMEM_REQ,
    output IMEM_ACK, IMEM_DATA,
    input  DMEM_ADDR, DMEM_RD, DMEM_WR, DMEM_WDATA,
    output DMEM_RDATA, DMEM_ACK,
    input  ALU_X, ALU_Y, ALU_CTRL,
    output ALU_OUT, ALU_ZR, ALU_NG,
    input  PC_OUT, A_OUT, D_OUT
  );

endinterface

// File: rtl/hack_jump_cond.sv
// Hack jump predicate: JGT/JEQ/JLT bits tested against the ALU result flags.
module hack_jump_cond (
  input  logic [2:0] JUMP,
  input  logic       ZR,
  input  logic       NG,
  output logic       JMP
);

  assign JMP = (JUMP[2] & NG) | (JUMP[1] & ZR) | (JUMP[0] & ~NG & ~ZR);

endmodule

// File: rtl/hack_cpu_seq.sv
// Multi-cycle Hack CPU sequencer: fetch/decode/execute FSM owning PC, A, D, IR,
// MDR, R and AOLD, with request/acknowledge instruction and data ports.
module hack_cpu_seq
  import hack_pkg::*;
(
  input  logic           CLK,
  input  logic           RESET,
  hack_cpu_seq_if.master bus
);

  state_t            state;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] a_reg;
  logic [DATA_W-1:0] d_reg;
  logic [DATA_W-1:0] mdr;
  logic [DATA_W-1:0] r_reg;
  logic [ADDR_W-1:0] aold;
  logic [ADDR_W-1:0] pc;
  logic              jmp_hold;
  logic              jmp_now;
  logic [2:0]        dest;

  assign dest = ir[DEST_HI:DEST_LO];

  hack_jump_cond u_jump (
    .JUMP (ir[JUMP_HI:JUMP_LO]),
    .ZR   (bus.ALU_ZR),
    .NG   (bus.ALU_NG),
    .JMP  (jmp_now)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= FETCH;
      pc       <= '0;
      a_reg    <= '0;
      d_reg    <= '0;
      ir       <= '0;
      mdr      <= '0;
      r_reg    <= '0;
      aold     <= '0;
      jmp_hold <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (bus.IMEM_ACK) begin
            ir    <= bus.IMEM_DATA;
            state <= DECODE;
          end
        end

        DECODE: begin
          if (!ir[IBIT_C]) begin
            a_reg <= ir;
            pc    <= pc_inc(pc);
            state <= FETCH;
          end else begin
            state <= ir[ABIT] ? MEM_RD : EXEC;
          end
        end

        MEM_RD: begin
          if (bus.DMEM_ACK) begin
            mdr   <= bus.DMEM_RDATA;
            state <= EXEC;
          end
        end

        // Jump target and store address both come from A as it was before this
        // instruction; the flags are only valid now, so the decision is kept.
        EXEC: begin
          r_reg    <= bus.ALU_OUT;
          aold     <= a_reg[ADDR_W-1:0];
          jmp_hold <= jmp_now;
          if (dest[2]) a_reg <= bus.ALU_OUT;
          if (dest[1]) d_reg <= bus.ALU_OUT;
          if (dest[0]) begin
            state <= MEM_WR;
          end else begin
            pc    <= jmp_now ? a_reg[ADDR_W-1:0] : pc_inc(pc);
            state <= FETCH;
          end
        end

        MEM_WR: begin
          if (bus.DMEM_ACK) begin
            pc    <= jmp_hold ? aold : pc_inc(pc);
            state <= FETCH;
          end
        end

        default: state <= FETCH;
      endcase
    end
  end

  // Strobes are decoded from state and gated by RESET so an abandoned
  // transaction drops its request in the reset cycle itself.
  assign bus.IMEM_REQ   = (state == FETCH)  && !RESET;
  assign bus.DMEM_RD    = (state == MEM_RD) && !RESET;
  assign bus.DMEM_WR    = (state == MEM_WR) && !RESET;
  assign bus.IMEM_ADDR  = pc;
  assign bus.DMEM_ADDR  = (state == MEM_WR) ? aold : a_reg[ADDR_W-1:0];
  assign bus.DMEM_WDATA = r_reg;

  assign bus.ALU_X    = d_reg;
  assign bus.ALU_Y    = ir[ABIT] ? mdr : a_reg;
  assign bus.ALU_CTRL = ir[CTRL_HI:CTRL_LO];

  assign bus.PC_OUT = pc;
  assign bus.A_OUT  = a_reg;
  assign bus.D_OUT  = d_reg;

endmodule

// File: tb/tb_hack_cpu_seq.sv
// Self-checking bench for hack_cpu_seq: table of instructions in execution order
// with hand-computed post-state, a data-port scoreboard and a reset-abort sequence.
module tb_hack_cpu_seq;

  logic CLK;
  logic RESET;

  hack_cpu_seq_if bus ();

  hack_cpu_seq dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference Hack ALU
  logic [15:0] ax, ay, ao;
  always_comb begin
    ax = bus.ALU_CTRL[5] ? 16'h0000 : bus.ALU_X;
    if (bus.ALU_CTRL[4]) ax = ~ax;
    ay = bus.ALU_CTRL[3] ? 16'h0000 : bus.ALU_Y;
    if (bus.ALU_CTRL[2]) ay = ~ay;
    ao = bus.ALU_CTRL[1] ? (ax + ay) : (ax & ay);
    if (bus.ALU_CTRL[0]) ao = ~ao;
  end
  assign bus.ALU_OUT = ao;
  assign bus.ALU_ZR  = (ao == 16'h0000);
  assign bus.ALU_NG  = ao[15];

  typedef struct {
    logic [15:0] instr;
    logic [14:0] pc;
    int          iwait;
    int          dwait;
    logic        mrd;
    logic        mwr;
    logic [14:0] maddr;
    logic [15:0] mdata;
    int          cyc;
    logic [15:0] a;
    logic [15:0] d;
    logic [14:0] npc;
  } vec_t;

  typedef struct {
    logic        wr;
    logic [14:0] addr;
    logic [15:0] data;
  } mexp_t;

  vec_t        vt[$];
  mexp_t       sb[$];
  logic [15:0] ram [0:32767];
  int          n_vec;
  int          n_err;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (vec %0d): got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    chk("strobe_excl", -1,
        {30'd0, bus.IMEM_REQ & (bus.DMEM_RD | bus.DMEM_WR), bus.DMEM_RD & bus.DMEM_WR}, 32'd0);
  endtask

  task automatic mem_pop(input int idx);
    mexp_t e;
    if (sb.size() == 0) begin
      chk("dmem_unexpected", idx, {31'd0, bus.DMEM_WR}, 32'hFFFF_FFFF);
    end else begin
      e = sb.pop_front();
      chk("dmem_kind", idx, {31'd0, bus.DMEM_WR}, {31'd0, e.wr});
      chk("dmem_addr", idx, {17'd0, bus.DMEM_ADDR}, {17'd0, e.addr});
      if (e.wr) chk("dmem_wdata", idx, {16'd0, bus.DMEM_WDATA}, {16'd0, e.data});
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int          n;
    int          g;
    int          dcnt;
    logic        rd_done;
    logic [16:0] hold0;
    logic [15:0] wd0;
    g = 0;
    while (!bus.IMEM_REQ && g < 64) begin
      step();
      g++;
    end
    if (g >= 64) chk("fetch_timeout", idx, 32'd0, 32'd1);
    if (v.mrd || v.mwr) sb.push_back('{v.mwr, v.maddr, v.mdata});
    chk("fetch_addr", idx, {17'd0, bus.IMEM_ADDR}, {17'd0, v.pc});
    n = 0;
    for (int i = 0; i < v.iwait; i++) begin
      step();
      n++;
      chk("fetch_hold", idx, {16'd0, bus.IMEM_REQ, bus.IMEM_ADDR}, {16'd0, 1'b1, v.pc});
    end
    bus.IMEM_ACK  = 1'b1;
    bus.IMEM_DATA = v.instr;
    step();
    n++;
    bus.IMEM_ACK  = 1'b0;
    bus.IMEM_DATA = 16'hFFFF;
    dcnt    = 0;
    rd_done = 1'b0;
    hold0   = '0;
    wd0     = '0;
    g       = 0;
    while (!bus.IMEM_REQ && g < 64) begin
      if (rd_done) begin
        chk("alu_y_mdr", idx, {16'd0, bus.ALU_Y}, {16'd0, v.mdata});
        rd_done = 1'b0;
      end
      if (bus.DMEM_RD || bus.DMEM_WR) begin
        if (dcnt == 0) begin
          hold0 = {bus.DMEM_RD, bus.DMEM_WR, bus.DMEM_ADDR};
          wd0   = bus.DMEM_WDATA;
        end else begin
          chk("dmem_hold", idx, {15'd0, bus.DMEM_RD, bus.DMEM_WR, bus.DMEM_ADDR}, {15'd0, hold0});
          if (hold0[15]) chk("dmem_hold_wdata", idx, {16'd0, bus.DMEM_WDATA}, {16'd0, wd0});
        end
        if (dcnt == v.dwait) begin
          bus.DMEM_ACK   = 1'b1;
          bus.DMEM_RDATA = ram[bus.DMEM_ADDR];
          if (bus.DMEM_WR) ram[bus.DMEM_ADDR] = bus.DMEM_WDATA;
          mem_pop(idx);
          rd_done = bus.DMEM_RD;
          dcnt    = 0;
        end else begin
          dcnt++;
        end
      end
      step();
      n++;
      g++;
      bus.DMEM_ACK   = 1'b0;
      bus.DMEM_RDATA = 16'hBAD0;
    end
    if (g >= 64) chk("exec_timeout", idx, 32'd0, 32'd1);
    chk("cycles", idx, n, v.cyc);
    chk("a_reg",  idx, {16'd0, bus.A_OUT}, {16'd0, v.a});
    chk("d_reg",  idx, {16'd0, bus.D_OUT}, {16'd0, v.d});
    chk("pc",     idx, {17'd0, bus.PC_OUT}, {17'd0, v.npc});
    chk("sb_drained", idx, sb.size(), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    RESET          = 1'b1;
    bus.IMEM_ACK   = 1'b0;
    bus.IMEM_DATA  = 16'h0000;
    bus.DMEM_ACK   = 1'b0;
    bus.DMEM_RDATA = 16'hBAD0;
    ram[3]  = 16'hFFFF;
    ram[10] = 16'h0000;
    ram[100] = 16'h0000;

    //            instr     pc        iw dw rd    wr    maddr    mdata     cyc A         D         npc
    vt.push_back('{16'h0005, 15'd0,    0, 0, 1'b0, 1'b0, 15'd0,   16'h0000, 2, 16'h0005, 16'h0000, 15'd1});
    vt.push_back('{16'hEC10, 15'd1,    0, 0, 1'b0, 1'b0, 15'd0,   16'h0000, 3, 16'h0005, 16'h0005, 15'd2});
    vt.push_back('{16'h0007, 15'd2,    0, 0, 1'b0, 1'b0, 15'd0,   16'h0000, 2, 16'h0007, 16'h0005, 15'd3});
    vt.push_back('{16'hEC10, 15'd3,    0, 0, 1'b0, 1'b0, 15'd0,   16'h0000, 3, 16'h0007, 16'h0007, 15'd4});
    vt.push_back('{16'h0064, 15'd4,    0, 0, 1'b0, 1'b0, 15'd0,   16'h0000, 2, 16'h0064, 16'h0007, 15'd5});
    vt.push_back('{16'hE7C8, 15'd5,    0, 3, 1'b0, 1'b1, 15'd100, 16'h0008, 7, 16'h0064, 16'h0007, 15'd6});
    vt.push_back('{16'h0003, 15'd6,    2, 0, 1'b0, 1'b0, 15'd0,   16'h0000, 4, 16'h0003, 16'h0007, 15'd7});
    vt.push_back('{16'hFC10, 15'd7,    0, 0, 1'b1, 1'b0, 15'd3,   16'hFFFF, 4, 16'h0003, 16'hFFFF, 15'd8});
    vt.push_back('{16'h000A, 15'd8,    0, 0, 1'b0, 1'b0, 15'd0,   16'h0000, 2, 16'h000A, 16'hFFFF, 15'd9});
    vt.push_back('{16'hE304, 15'd9,    0, 0, 1'b0, 1'b0, 15'd0,   16'h0000, 3, 16'h000A, 16'hFFFF, 15'd10});
    vt.push_back('{16'hEA90, 15'd10,   0, 0, 1'b0, 1'b0, 15'd0,   16'h0000, 3, 16'h000A, 16'h0000, 15'd11});
    vt.push_back('{16'h000A, 15'd11,   0, 0, 1'b0, 1'b0, 15'd0,   16'h0000, 2, 16'h000A, 16'h0000, 15'd12});
    vt.push_back('{16'hE304, 15'd12,   0, 0, 1'b0, 1'b0, 15'd0,   16'h0000, 3, 16'h000A, 16'h0000, 15'd13});
    vt.push_back('{16'hEA87, 15'd13,   0, 0, 1'b0, 1'b0, 15'd0,   16'h0000, 3, 16'h000A, 16'h0000, 15'd10});
    vt.push_back('{16'h0014, 15'd10,   0, 0, 1'b0, 1'b0, 15'd0,   16'h0000, 2, 16'h0014, 16'h0000, 15'd11});
    vt.push_back('{16'hEC10, 15'd11,   0, 0, 1'b0, 1'b0, 15'd0,   16'h0000, 3, 16'h0014, 16'h0014, 15'd12});
    vt.push_back('{16'h000A, 15'd12,   0, 0, 1'b0, 1'b0, 15'd0,   16'h0000, 2, 16'h000A, 16'h0014, 15'd13});
    vt.push_back('{16'hE32F, 15'd13,   0, 1, 1'b0, 1'b1, 15'd10,  16'h0014, 5, 16'h0014, 16'h0014, 15'd10});
    vt.push_back('{16'h7FFF, 15'd10,   0, 0, 1'b0, 1'b0, 15'd0,   16'h0000, 2, 16'h7FFF, 16'h0014, 15'd11});
    vt.push_back('{16'hEA87, 15'd11,   1, 0, 1'b0, 1'b0, 15'd0,   16'h0000, 4, 16'h7FFF, 16'h0014, 15'h7FFF});
    vt.push_back('{16'h0000, 15'h7FFF, 0, 0, 1'b0, 1'b0, 15'd0,   16'h0000, 2, 16'h0000, 16'h0014, 15'd0});
    vt.push_back('{16'h0003, 15'd0,    0, 0, 1'b0, 1'b0, 15'd0,   16'h0000, 2, 16'h0003, 16'h0014, 15'd1});

    repeat (3) step();
    chk("rst_strobes", -1, {29'd0, bus.IMEM_REQ, bus.DMEM_RD, bus.DMEM_WR}, 32'd0);
    chk("rst_pc", -1, {17'd0, bus.PC_OUT}, 32'd0);
    chk("rst_a",  -1, {16'd0, bus.A_OUT}, 32'd0);
    chk("rst_d",  -1, {16'd0, bus.D_OUT}, 32'd0);
    RESET = 1'b0;
    #1;
    chk("first_req", -1, {16'd0, bus.IMEM_REQ, bus.IMEM_ADDR}, {16'd0, 1'b1, 15'd0});

    foreach (vt[i]) run_vec(vt[i], i);

    // Reset while a data read is waiting for its acknowledge
    chk("mr_fetch", 100, {16'd0, bus.IMEM_REQ, bus.IMEM_ADDR}, {16'd0, 1'b1, 15'd1});
    bus.IMEM_ACK  = 1'b1;
    bus.IMEM_DATA = 16'hFC10;
    step();
    bus.IMEM_ACK  = 1'b0;
    step();
    chk("mr_rd_req", 100, {16'd0, bus.DMEM_RD, bus.DMEM_ADDR}, {16'd0, 1'b1, 15'd3});
    step();
    chk("mr_rd_hold", 100, {16'd0, bus.DMEM_RD, bus.DMEM_ADDR}, {16'd0, 1'b1, 15'd3});
    RESET = 1'b1;
    #1;
    chk("mr_rst_strobes", 100, {29'd0, bus.IMEM_REQ, bus.DMEM_RD, bus.DMEM_WR}, 32'd0);
    step();
    chk("mr_rst_strobes2", 100, {29'd0, bus.IMEM_REQ, bus.DMEM_RD, bus.DMEM_WR}, 32'd0);
    chk("mr_rst_pc", 100, {17'd0, bus.PC_OUT}, 32'd0);
    RESET          = 1'b0;
    bus.DMEM_ACK   = 1'b1;
    bus.DMEM_RDATA = 16'h1234;
    #1;
    chk("mr_refetch", 100, {16'd0, bus.IMEM_REQ, bus.IMEM_ADDR}, {16'd0, 1'b1, 15'd0});
    chk("mr_rd_dropped", 100, {31'd0, bus.DMEM_RD}, 32'd0);
    step();
    bus.DMEM_ACK   = 1'b0;
    bus.DMEM_RDATA = 16'hBAD0;
    chk("mr_late_ack_a", 100, {16'd0, bus.A_OUT}, 32'd0);
    chk("mr_late_ack_d", 100, {16'd0, bus.D_OUT}, 32'd0);
    chk("mr_still_fetch", 100, {16'd0, bus.IMEM_REQ, bus.IMEM_ADDR}, {16'd0, 1'b1, 15'd0});
    run_vec('{16'h0009, 15'd0, 0, 0, 1'b0, 1'b0, 15'd0, 16'h0000, 2, 16'h0009, 16'h0000, 15'd1}, 200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
